// File: rtl/spu_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of the SPU slave port; one grant per classic cycle.
// Optional ack watchdog enabled by defining SPU_WB_ARB_TIMEOUT_EN.
module spu_wb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int WB_ADR_BITS    = 13,
  parameter int WB_DAT_BITS    = 64,
  parameter int WB_SEL_BITS    = WB_DAT_BITS / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [NUM_MASTERS*WB_ADR_BITS-1:0] s_wb_adr_i,
  input  logic [NUM_MASTERS*WB_DAT_BITS-1:0] s_wb_dat_i,
  input  logic [NUM_MASTERS*WB_SEL_BITS-1:0] s_wb_sel_i,
  input  logic [NUM_MASTERS-1:0]             s_wb_we_i,
  input  logic [NUM_MASTERS-1:0]             s_wb_stb_i,
  output logic [WB_DAT_BITS-1:0]             s_wb_dat_o,
  output logic [NUM_MASTERS-1:0]             s_wb_ack_o,
  output logic [NUM_MASTERS-1:0]             s_wb_err_o,
  output logic [WB_ADR_BITS-1:0]             m_wb_adr_o,
  output logic [WB_DAT_BITS-1:0]             m_wb_dat_o,
  output logic [WB_SEL_BITS-1:0]             m_wb_sel_o,
  output logic                               m_wb_we_o,
  output logic                               m_wb_stb_o,
  input  logic [WB_DAT_BITS-1:0]             m_wb_dat_i,
  input  logic                               m_wb_ack_i,
  output logic [NUM_MASTERS-1:0]             grant_o,
  output logic                               timeout_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [WB_ADR_BITS-1:0] adr_q, adr_d;
  logic [WB_DAT_BITS-1:0] dat_q, dat_d;
  logic [WB_SEL_BITS-1:0] sel_q, sel_d;
  logic                   we_q, we_d;
  logic                   stb_q, stb_d;

  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  int                     cand;
  logic                   ack_hit;
  logic                   tmo_hit;

  // Search starts just after the last completed grant, wrapping at NUM_MASTERS.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = (int'(last_q) + i) % NUM_MASTERS;
      if (!pick_found && s_wb_stb_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign ack_hit = m_wb_ack_i & stb_q;

`ifdef SPU_WB_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        timeout_q;

  // An ack in the limit cycle takes precedence over the watchdog.
  assign tmo_hit = stb_q & ~m_wb_ack_i & (cnt_q == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) cnt_q <= '0;
      else if (!m_wb_ack_i)   cnt_q <= cnt_q + 16'd1;
      if (tmo_hit) timeout_q <= 1'b1;
    end
  end

  assign timeout_o  = timeout_q;
  assign s_wb_err_o = tmo_hit ? grant_q : '0;
`else
  assign tmo_hit    = 1'b0;
  assign timeout_o  = 1'b0;
  assign s_wb_err_o = '0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    stb_d   = stb_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_BUSY;
          grant_d = NUM_MASTERS'(1) << pick_idx;
          gidx_d  = pick_idx;
          adr_d   = s_wb_adr_i[pick_idx*WB_ADR_BITS +: WB_ADR_BITS];
          dat_d   = s_wb_dat_i[pick_idx*WB_DAT_BITS +: WB_DAT_BITS];
          sel_d   = s_wb_sel_i[pick_idx*WB_SEL_BITS +: WB_SEL_BITS];
          we_d    = s_wb_we_i[pick_idx];
          stb_d   = 1'b1;
        end
      end
      default: begin
        if (ack_hit || tmo_hit) begin
          state_d = ST_IDLE;
          grant_d = '0;
          stb_d   = 1'b0;
          last_d  = gidx_q;
        end else if (!s_wb_stb_i[gidx_q]) begin
          // Abandoned cycle: priority pointer is left where it was.
          state_d = ST_IDLE;
          grant_d = '0;
          stb_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
    end
  end

  assign s_wb_ack_o = ack_hit ? grant_q : '0;
  assign s_wb_dat_o = m_wb_dat_i;
  assign m_wb_adr_o = adr_q;
  assign m_wb_dat_o = dat_q;
  assign m_wb_sel_o = sel_q;
  assign m_wb_we_o  = we_q;
  assign m_wb_stb_o = stb_q;
  assign grant_o    = grant_q;

endmodule

// File: tb/tb_spu_wb_arbiter.sv
// Directed bench for spu_wb_arbiter (2 masters); expected transfers are queued when requests are driven.
module tb_spu_wb_arbiter;

  localparam int NM = 2;
  localparam int AW = 13;
  localparam int DW = 64;
  localparam int SW = 8;

  logic           aclk;
  logic           aresetn;
  logic [NM*AW-1:0] s_adr;
  logic [NM*DW-1:0] s_dat;
  logic [NM*SW-1:0] s_sel;
  logic [NM-1:0]  s_we;
  logic [NM-1:0]  s_stb;
  logic [DW-1:0]  s_dat_o;
  logic [NM-1:0]  s_ack;
  logic [NM-1:0]  s_err;
  logic [AW-1:0]  m_adr;
  logic [DW-1:0]  m_dat;
  logic [SW-1:0]  m_sel;
  logic           m_we;
  logic           m_stb;
  logic [DW-1:0]  m_dat_i;
  logic           m_ack;
  logic [NM-1:0]  grant;
  logic           tmo;

  spu_wb_arbiter #(
    .NUM_MASTERS(NM), .WB_ADR_BITS(AW), .WB_DAT_BITS(DW), .WB_SEL_BITS(SW), .TIMEOUT_CYCLES(4)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_wb_adr_i(s_adr), .s_wb_dat_i(s_dat), .s_wb_sel_i(s_sel), .s_wb_we_i(s_we),
    .s_wb_stb_i(s_stb), .s_wb_dat_o(s_dat_o), .s_wb_ack_o(s_ack), .s_wb_err_o(s_err),
    .m_wb_adr_o(m_adr), .m_wb_dat_o(m_dat), .m_wb_sel_o(m_sel), .m_wb_we_o(m_we),
    .m_wb_stb_o(m_stb), .m_wb_dat_i(m_dat_i), .m_wb_ack_i(m_ack),
    .grant_o(grant), .timeout_o(tmo)
  );

  typedef struct {
    int          m;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic        we;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic w);
    exp_t e;
    s_adr[m*AW +: AW] = a;
    s_dat[m*DW +: DW] = d;
    s_sel[m*SW +: SW] = s;
    s_we[m]  = w;
    s_stb[m] = 1'b1;
    e.m = m; e.adr = a; e.dat = d; e.sel = s; e.we = w;
    sbq.push_back(e);
  endtask

  // Called in the first BUSY cycle; returns the served master after the completion edge.
  task automatic serve_one(input int waits, input logic [DW-1:0] rdat, output int m);
    exp_t e;
    logic [NM-1:0] g;
    m = 0;
    chk("stb_rise", 64'(m_stb), 64'd1);
    chk("sb_nonempty", 64'(sbq.size() > 0), 64'd1);
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    m = e.m;
    g = NM'(1) << e.m;
    chk("grant", 64'(grant), 64'(g));
    chk("m_adr", 64'(m_adr), 64'(e.adr));
    chk("m_dat", m_dat, e.dat);
    chk("m_sel", 64'(m_sel), 64'(e.sel));
    chk("m_we", 64'(m_we), 64'(e.we));
    for (int w = 0; w < waits; w++) begin
      m_ack = 1'b0;
      #1;
      chk("ack_wait", 64'(s_ack), 64'd0);
      tick();
      chk("adr_stable", 64'(m_adr), 64'(e.adr));
      chk("stb_hold", 64'(m_stb), 64'd1);
    end
    m_ack   = 1'b1;
    m_dat_i = rdat;
    #1;
    chk("ack_fwd", 64'(s_ack), 64'(g));
    chk("rdata", s_dat_o, rdat);
    tick();
    m_ack = 1'b0;
    chk("stb_fall", 64'(m_stb), 64'd0);
    chk("grant_clr", 64'(grant), 64'd0);
  endtask

  initial begin
    int m;
    int cnt [NM];
    exp_t e;
    aresetn = 1'b0;
    s_adr = '0; s_dat = '0; s_sel = '0; s_we = '0; s_stb = '0;
    m_dat_i = '0; m_ack = 1'b0;
    #2;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_stb", 64'(m_stb), 64'd0);
    chk("rst_adr", 64'(m_adr), 64'd0);
    chk("rst_dat", m_dat, 64'd0);
    chk("rst_sel", 64'(m_sel), 64'd0);
    chk("rst_we", 64'(m_we), 64'd0);
    chk("rst_err", 64'(s_err), 64'd0);
    chk("rst_tmo", 64'(tmo), 64'd0);
    tick(); tick();
    aresetn = 1'b1;
    tick();

    // Single write from master 1 with a zero-wait SPU.
    set_req(1, 13'h010, 64'h1122334455667788, 8'hFF, 1'b1);
    tick();
    serve_one(0, 64'h0, m);
    s_stb[1] = 1'b0;
    tick();
    chk("idle_stb", 64'(m_stb), 64'd0);
    m_ack = 1'b1;
    #1;
    chk("idle_ack_ignored", 64'(s_ack), 64'd0);
    tick();
    chk("idle_ack_stb", 64'(m_stb), 64'd0);
    chk("idle_ack_grant", 64'(grant), 64'd0);
    m_ack = 1'b0;

    // Continuous reads from both masters: grants alternate, one idle cycle between strobes.
    cnt[0] = 0; cnt[1] = 0;
    set_req(0, 13'h100, 64'h0, 8'hFF, 1'b0);
    set_req(1, 13'h200, 64'h0, 8'hFF, 1'b0);
    tick();
    for (int n = 0; n < 8; n++) begin
      serve_one(0, 64'hA000 + 64'(n), m);
      cnt[m]++;
      if (cnt[m] < 4) set_req(m, 13'((m + 1) * 13'h100 + cnt[m]), 64'h0, 8'hFF, 1'b0);
      else s_stb[m] = 1'b0;
      tick();
    end
    chk("rr_drained", 64'(sbq.size()), 64'd0);

    // Master 0 abandons its cycle; it keeps priority over master 1 afterwards.
    set_req(0, 13'h030, 64'h0, 8'h0F, 1'b0);
    tick();
    chk("ab_stb", 64'(m_stb), 64'd1);
    e = sbq.pop_front();
    chk("ab_grant", 64'(grant), 64'd1);
    tick();
    chk("ab_busy2", 64'(m_stb), 64'd1);
    s_stb[0] = 1'b0;
    tick();
    chk("ab_idle_stb", 64'(m_stb), 64'd0);
    chk("ab_idle_grant", 64'(grant), 64'd0);
    set_req(0, 13'h031, 64'h0, 8'hFF, 1'b0);
    set_req(1, 13'h032, 64'h0, 8'hFF, 1'b0);
    tick();
    serve_one(0, 64'h5, m);
    chk("ab_prio", 64'(m), 64'd0);
    s_stb[0] = 1'b0;
    tick();
    serve_one(0, 64'h6, m);
    s_stb[1] = 1'b0;
    tick();

    // Read with three wait states.
    set_req(0, 13'h020, 64'h0, 8'hFF, 1'b0);
    tick();
    serve_one(3, 64'hDEADBEEF, m);
    s_stb[0] = 1'b0;
    tick();

    // SPU never acks master 1.
    set_req(1, 13'h040, 64'h0, 8'hFF, 1'b0);
    tick();
    chk("st_stb", 64'(m_stb), 64'd1);
    e = sbq.pop_front();
    chk("st_grant", 64'(grant), 64'd2);
`ifdef SPU_WB_ARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      chk("to_err_early", 64'(s_err), 64'd0);
      tick();
    end
    chk("to_err_pulse", 64'(s_err), 64'd2);
    chk("to_no_ack", 64'(s_ack), 64'd0);
    tick();
    chk("to_err_done", 64'(s_err), 64'd0);
    chk("to_sticky", 64'(tmo), 64'd1);
    chk("to_stb", 64'(m_stb), 64'd0);
    chk("to_grant", 64'(grant), 64'd0);
    s_stb[1] = 1'b0;
    set_req(0, 13'h041, 64'h0, 8'hFF, 1'b0);
    tick();
    serve_one(0, 64'h77, m);
    s_stb[0] = 1'b0;
    tick();
    chk("to_still_sticky", 64'(tmo), 64'd1);
`else
    for (int c = 1; c <= 6; c++) begin
      chk("st_err", 64'(s_err), 64'd0);
      chk("st_tmo", 64'(tmo), 64'd0);
      chk("st_hold", 64'(m_stb), 64'd1);
      tick();
    end
    m_ack = 1'b1;
    #1;
    chk("st_ack", 64'(s_ack), 64'd2);
    tick();
    m_ack = 1'b0;
    chk("st_done", 64'(m_stb), 64'd0);
    s_stb[1] = 1'b0;
    tick();
`endif

    // Reset in the middle of a transfer.
    set_req(1, 13'h050, 64'h0, 8'hFF, 1'b0);
    tick();
    chk("rm_stb", 64'(m_stb), 64'd1);
    e = sbq.pop_front();
    chk("rm_grant", 64'(grant), 64'd2);
    m_ack   = 1'b1;
    aresetn = 1'b0;
    #1;
    chk("rm_stb_drop", 64'(m_stb), 64'd0);
    chk("rm_grant_drop", 64'(grant), 64'd0);
    chk("rm_no_ack", 64'(s_ack), 64'd0);
    chk("rm_no_err", 64'(s_err), 64'd0);
    chk("rm_tmo_clr", 64'(tmo), 64'd0);
    m_ack = 1'b0;
    s_stb = '0;
    tick();
    aresetn = 1'b1;
    set_req(0, 13'h060, 64'h0, 8'hFF, 1'b0);
    set_req(1, 13'h061, 64'h0, 8'hFF, 1'b0);
    tick();
    serve_one(0, 64'h11, m);
    chk("rm_prio", 64'(m), 64'd0);
    s_stb[0] = 1'b0;
    tick();
    serve_one(0, 64'h12, m);
    s_stb[1] = 1'b0;
    tick();
    chk("final_drained", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
